// File: rtl/rv32_periph_pkg.sv
// Shared types and helpers for the peripheral bus arbiter: FSM states,
// address regions and the region decode / cycle-select functions.
package rv32_periph_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        REG_UART = 2'd0,
        REG_SPI  = 2'd1,
        REG_VGA  = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    // Two most-significant address bits select the peripheral region.
    function automatic region_e region_decode(input logic [1:0] top_bits);
        region_e r;
        case (top_bits)
            2'b00:   r = REG_UART;
            2'b01:   r = REG_SPI;
            2'b10:   r = REG_VGA;
            default: r = REG_NONE;
        endcase
        return r;
    endfunction

    // One-hot per-slave CYC vector {vga, spi, uart}; unmapped drives nothing.
    function automatic logic [2:0] cyc_onehot(input region_e r);
        logic [2:0] v;
        case (r)
            REG_UART: v = 3'b001;
            REG_SPI:  v = 3'b010;
            REG_VGA:  v = 3'b100;
            default:  v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rv32_periph_bus_arbiter_if.sv
// Requester ports and shared Wishbone peripheral bus seen by the arbiter.
// The master modport is the arbiter (it masters the peripheral bus);
// the slave modport is the environment: requesters plus peripherals.
interface rv32_periph_bus_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              m0_req_i;
    logic              m0_we_i;
    logic [3:0]        m0_sel_i;
    logic [ADDR_W-1:0] m0_adr_i;
    logic [31:0]       m0_dat_i;
    logic              m0_ack_o;
    logic              m0_err_o;
    logic [31:0]       m0_dat_o;

    logic              m1_req_i;
    logic              m1_we_i;
    logic [3:0]        m1_sel_i;
    logic [ADDR_W-1:0] m1_adr_i;
    logic [31:0]       m1_dat_i;
    logic              m1_ack_o;
    logic              m1_err_o;
    logic [31:0]       m1_dat_o;

    logic [ADDR_W-1:0] wb_adr_o;
    logic [31:0]       wb_dat_o;
    logic              wb_we_o;
    logic              wb_stb_o;
    logic [3:0]        wb_sel_o;
    logic              uart_cyc_o;
    logic              spi_cyc_o;
    logic              vga_cyc_o;
    logic              uart_ack_i;
    logic              spi_ack_i;
    logic              vga_ack_i;
    logic [31:0]       uart_dat_i;
    logic [31:0]       spi_dat_i;
    logic              busy_o;

    modport master (
        input  m0_req_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_req_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_sel_o,
        output uart_cyc_o, spi_cyc_o, vga_cyc_o,
        input  uart_ack_i, spi_ack_i, vga_ack_i, uart_dat_i, spi_dat_i,
        output busy_o
    );

    modport slave (
        output m0_req_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_req_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_sel_o,
        input  uart_cyc_o, spi_cyc_o, vga_cyc_o,
        output uart_ack_i, spi_ack_i, vga_ack_i, uart_dat_i, spi_dat_i,
        input  busy_o
    );

endinterface

// File: rtl/rv32_rr_arbiter2.sv
// Two-way round-robin grant. A lone request wins outright; on contention the
// requester that did not win last time is chosen. last_grant resets to 1 so
// requester 0 wins the first contention.
module rv32_rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       valid_o,
    output logic       grant_o
);

    logic last_grant_r;

    // Grant selection from the current requests and the previous winner.
    always_comb begin
        valid_o = |req_i;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_grant_r;
            default: grant_o = 1'b0;
        endcase
    end

    // Remember the winner whenever a grant is actually taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_r <= 1'b1;
        end else if (update_i && valid_o) begin
            last_grant_r <= grant_o;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/rv32_periph_bus_arbiter.sv
// Shares the UART/SPI/VGA Wishbone peripheral bus between the CPU load/store
// port (m0) and the DMA/boot-loader (m1). One classic cycle at a time:
// IDLE latches the granted request, BUS holds CYC/STB until ACK or timeout,
// RESP returns a one-cycle ack to the granted requester. Unmapped addresses
// skip the bus and answer with an error straight away.
module rv32_periph_bus_arbiter
    import rv32_periph_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    rv32_periph_bus_arbiter_if.master bus
);

    arb_state_e        state_r, state_n;
    region_e           region_r, region_n;
    logic              grant_r, grant_n;
    logic [TO_W-1:0]   cnt_r, cnt_n;
    logic [ADDR_W-1:0] wb_adr_r, wb_adr_n;
    logic [31:0]       wb_dat_r, wb_dat_n;
    logic              wb_we_r, wb_we_n;
    logic [3:0]        wb_sel_r, wb_sel_n;
    logic              stb_r, stb_n;
    logic [2:0]        cyc_r, cyc_n;
    logic [1:0]        ack_r, ack_n;
    logic [1:0]        err_r, err_n;
    logic [31:0]       m0_dat_r, m0_dat_n;
    logic [31:0]       m1_dat_r, m1_dat_n;
    logic              busy_r;

    logic [1:0]        req_s;
    logic              grant_valid_s;
    logic              grant_s;
    logic              update_s;
    logic              pick_we_s;
    logic [3:0]        pick_sel_s;
    logic [ADDR_W-1:0] pick_adr_s;
    logic [31:0]       pick_dat_s;
    region_e           pick_region_s;
    logic              slave_ack_s;
    logic [31:0]       slave_dat_s;
    logic              done_s;
    logic              done_err_s;
    logic [31:0]       done_dat_s;
    logic              done_grant_s;

    assign req_s    = {bus.m1_req_i, bus.m0_req_i};
    assign update_s = (state_r == IDLE);

    rv32_rr_arbiter2 u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_s),
        .update_i (update_s),
        .valid_o  (grant_valid_s),
        .grant_o  (grant_s)
    );

    assign pick_we_s     = grant_s ? bus.m1_we_i  : bus.m0_we_i;
    assign pick_sel_s    = grant_s ? bus.m1_sel_i : bus.m0_sel_i;
    assign pick_adr_s    = grant_s ? bus.m1_adr_i : bus.m0_adr_i;
    assign pick_dat_s    = grant_s ? bus.m1_dat_i : bus.m0_dat_i;
    assign pick_region_s = region_decode(pick_adr_s[ADDR_W-1:ADDR_W-2]);

    // Only the addressed slave's ACK and data matter; VGA reads return zero.
    always_comb begin
        case (region_r)
            REG_UART: begin
                slave_ack_s = bus.uart_ack_i;
                slave_dat_s = bus.uart_dat_i;
            end
            REG_SPI: begin
                slave_ack_s = bus.spi_ack_i;
                slave_dat_s = bus.spi_dat_i;
            end
            REG_VGA: begin
                slave_ack_s = bus.vga_ack_i;
                slave_dat_s = 32'h0000_0000;
            end
            default: begin
                slave_ack_s = 1'b0;
                slave_dat_s = 32'h0000_0000;
            end
        endcase
    end

    // Next-state and next-output logic for the IDLE -> BUS -> RESP sequence.
    always_comb begin
        state_n      = state_r;
        region_n     = region_r;
        grant_n      = grant_r;
        cnt_n        = cnt_r;
        wb_adr_n     = wb_adr_r;
        wb_dat_n     = wb_dat_r;
        wb_we_n      = wb_we_r;
        wb_sel_n     = wb_sel_r;
        stb_n        = stb_r;
        cyc_n        = cyc_r;
        done_s       = 1'b0;
        done_err_s   = 1'b0;
        done_dat_s   = 32'h0000_0000;
        done_grant_s = grant_r;

        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    grant_n      = grant_s;
                    region_n     = pick_region_s;
                    done_grant_s = grant_s;
                    if (pick_region_s == REG_NONE) begin
                        state_n    = RESP;
                        done_s     = 1'b1;
                        done_err_s = 1'b1;
                    end else begin
                        state_n  = BUS;
                        cnt_n    = {TO_W{1'b0}};
                        wb_adr_n = pick_adr_s;
                        wb_dat_n = pick_dat_s;
                        wb_we_n  = pick_we_s;
                        wb_sel_n = pick_sel_s;
                        stb_n    = 1'b1;
                        cyc_n    = cyc_onehot(pick_region_s);
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            BUS: begin
                if (slave_ack_s || (cnt_r == TO_W'(TIMEOUT - 1))) begin
                    // An ACK on the final allowed cycle still counts as success.
                    state_n    = RESP;
                    done_s     = 1'b1;
                    done_err_s = ~slave_ack_s;
                    done_dat_s = slave_ack_s ? slave_dat_s : 32'h0000_0000;
                    wb_adr_n   = {ADDR_W{1'b0}};
                    wb_dat_n   = 32'h0000_0000;
                    wb_we_n    = 1'b0;
                    wb_sel_n   = 4'b0000;
                    stb_n      = 1'b0;
                    cyc_n      = 3'b000;
                end else begin
                    cnt_n = cnt_r + TO_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                stb_n   = 1'b0;
                cyc_n   = 3'b000;
            end
        endcase

        ack_n    = done_s ? (done_grant_s ? 2'b10 : 2'b01) : 2'b00;
        err_n    = (done_s && done_err_s) ? (done_grant_s ? 2'b10 : 2'b01) : 2'b00;
        m0_dat_n = (done_s && !done_grant_s) ? done_dat_s : 32'h0000_0000;
        m1_dat_n = (done_s && done_grant_s) ? done_dat_s : 32'h0000_0000;
    end

    // State and registered outputs; reset clears everything, including a live cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            region_r <= REG_UART;
            grant_r  <= 1'b0;
            cnt_r    <= {TO_W{1'b0}};
            wb_adr_r <= {ADDR_W{1'b0}};
            wb_dat_r <= 32'h0000_0000;
            wb_we_r  <= 1'b0;
            wb_sel_r <= 4'b0000;
            stb_r    <= 1'b0;
            cyc_r    <= 3'b000;
            ack_r    <= 2'b00;
            err_r    <= 2'b00;
            m0_dat_r <= 32'h0000_0000;
            m1_dat_r <= 32'h0000_0000;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            region_r <= region_n;
            grant_r  <= grant_n;
            cnt_r    <= cnt_n;
            wb_adr_r <= wb_adr_n;
            wb_dat_r <= wb_dat_n;
            wb_we_r  <= wb_we_n;
            wb_sel_r <= wb_sel_n;
            stb_r    <= stb_n;
            cyc_r    <= cyc_n;
            ack_r    <= ack_n;
            err_r    <= err_n;
            m0_dat_r <= m0_dat_n;
            m1_dat_r <= m1_dat_n;
            busy_r   <= (state_n != IDLE);
        end
    end

    assign bus.wb_adr_o   = wb_adr_r;
    assign bus.wb_dat_o   = wb_dat_r;
    assign bus.wb_we_o    = wb_we_r;
    assign bus.wb_sel_o   = wb_sel_r;
    assign bus.wb_stb_o   = stb_r;
    assign bus.uart_cyc_o = cyc_r[0];
    assign bus.spi_cyc_o  = cyc_r[1];
    assign bus.vga_cyc_o  = cyc_r[2];
    assign bus.m0_ack_o   = ack_r[0];
    assign bus.m1_ack_o   = ack_r[1];
    assign bus.m0_err_o   = err_r[0];
    assign bus.m1_err_o   = err_r[1];
    assign bus.m0_dat_o   = m0_dat_r;
    assign bus.m1_dat_o   = m1_dat_r;
    assign bus.busy_o     = busy_r;

endmodule

// File: tb/tb_rv32_periph_bus_arbiter.sv
// Directed bench for rv32_periph_bus_arbiter (TIMEOUT=8). Inputs are driven
// and outputs sampled on the falling edge; cycle 0 is the rising edge on
// which a new request is first seen.
module tb_rv32_periph_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   check_cnt = 0;
    int   err_cnt   = 0;

    always #5 clk = ~clk;

    rv32_periph_bus_arbiter_if #(.ADDR_W(16)) bif ();

    rv32_periph_bus_arbiter #(
        .ADDR_W  (16),
        .TIMEOUT (8),
        .TO_W    (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif.master)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_master(input bit m, input bit req, input bit we, input logic [3:0] sel,
                                input logic [15:0] adr, input logic [31:0] dat);
        if (m) begin
            bif.m1_req_i = req; bif.m1_we_i = we; bif.m1_sel_i = sel;
            bif.m1_adr_i = adr; bif.m1_dat_i = dat;
        end else begin
            bif.m0_req_i = req; bif.m0_we_i = we; bif.m0_sel_i = sel;
            bif.m0_adr_i = adr; bif.m0_dat_i = dat;
        end
    endtask

    task automatic check_quiet(input string tag);
        check_value({tag, "/cyc"}, {29'd0, bif.vga_cyc_o, bif.spi_cyc_o, bif.uart_cyc_o}, 32'd0);
        check_value({tag, "/ctl"}, {26'd0, bif.wb_stb_o, bif.wb_we_o, bif.busy_o, bif.m0_ack_o,
                                    bif.m1_ack_o, bif.m0_err_o | bif.m1_err_o}, 32'd0);
        check_value({tag, "/adr"}, {16'd0, bif.wb_adr_o}, 32'd0);
        check_value({tag, "/rdat"}, bif.m0_dat_o | bif.m1_dat_o, 32'd0);
    endtask

    // Runs one transaction for master m; exp_slave 0=UART 1=SPI 2=VGA 3=none.
    // ack_delay<0 means the slave never acknowledges; stray raises the ACKs
    // of every non-addressed slave for the whole transaction.
    task automatic do_txn(input string tag, input bit m, input bit we, input logic [3:0] sel,
                          input logic [15:0] adr, input logic [31:0] wdat, input int ack_delay,
                          input bit stray, input int exp_slave, input int exp_cyc,
                          input int exp_ack_cyc, input bit exp_err, input logic [31:0] exp_dat);
        int          cyc_cnt = 0;
        int          ack_cyc = -1;
        bit          wrong   = 1'b0;
        bit          other   = 1'b0;
        logic        err_seen = 1'b0;
        logic [31:0] dat_seen = 32'd0;
        logic [2:0]  cyc_v;
        logic [2:0]  exp_v;
        logic [2:0]  ack_v;
        exp_v = (exp_slave == 3) ? 3'b000 : (3'b001 << exp_slave);
        drive_master(m, 1'b1, we, sel, adr, wdat);
        for (int c = 1; c <= 60 && ack_cyc < 0; c++) begin
            @(negedge clk);
            cyc_v = {bif.vga_cyc_o, bif.spi_cyc_o, bif.uart_cyc_o};
            if (cyc_v != 3'b000) begin
                cyc_cnt++;
                if (cyc_v != exp_v) wrong = 1'b1;
                if (cyc_cnt == 1) begin
                    check_value({tag, "/wb_we"},  {31'd0, bif.wb_we_o}, {31'd0, we});
                    check_value({tag, "/wb_sel"}, {28'd0, bif.wb_sel_o}, {28'd0, sel});
                    check_value({tag, "/wb_adr"}, {16'd0, bif.wb_adr_o}, {16'd0, adr});
                    check_value({tag, "/wb_dat"}, bif.wb_dat_o, wdat);
                    check_value({tag, "/wb_stb"}, {31'd0, bif.wb_stb_o}, 32'd1);
                end
            end
            if ((m ? {bif.m0_ack_o, bif.m0_err_o, bif.m0_dat_o}
                   : {bif.m1_ack_o, bif.m1_err_o, bif.m1_dat_o}) != 34'd0) other = 1'b1;
            if (m ? bif.m1_ack_o : bif.m0_ack_o) begin
                ack_cyc  = c;
                err_seen = m ? bif.m1_err_o : bif.m0_err_o;
                dat_seen = m ? bif.m1_dat_o : bif.m0_dat_o;
                drive_master(m, 1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
                ack_v = 3'b000;
            end else begin
                ack_v = stray ? ~exp_v : 3'b000;
                if (ack_delay >= 0 && c == 1 + ack_delay) ack_v = ack_v | exp_v;
            end
            {bif.vga_ack_i, bif.spi_ack_i, bif.uart_ack_i} = ack_v;
        end
        drive_master(m, 1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        {bif.vga_ack_i, bif.spi_ack_i, bif.uart_ack_i} = 3'b000;
        check_value({tag, "/cyc_cycles"}, cyc_cnt, exp_cyc);
        check_value({tag, "/ack_cycle"}, ack_cyc, exp_ack_cyc);
        check_value({tag, "/err"}, {31'd0, err_seen}, {31'd0, exp_err});
        check_value({tag, "/rdat"}, dat_seen, exp_dat);
        check_value({tag, "/wrong_slave"}, {31'd0, wrong}, 32'd0);
        check_value({tag, "/other_master"}, {31'd0, other}, 32'd0);
        @(negedge clk);
        check_quiet({tag, "/after"});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int a0, a1, winner, any_ack;
        drive_master(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        drive_master(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        {bif.vga_ack_i, bif.spi_ack_i, bif.uart_ack_i} = 3'b000;
        bif.uart_dat_i = 32'd0;
        bif.spi_dat_i  = 32'd0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: m0 UART read, slave acks after 3 cycles
        bif.uart_dat_i = 32'hA5A5_0001;
        do_txn("t1_uart_rd", 1'b0, 1'b0, 4'hF, 16'h0004, 32'd0, 3, 1'b0, 0, 4, 5, 1'b0, 32'hA5A5_0001);

        // 2: simultaneous requests alternate m0, m1, m0, m1 after reset
        pulse_reset();
        bif.uart_dat_i = 32'h0000_00C3;
        for (int r = 0; r < 4; r++) begin
            a0 = 0; a1 = 0; winner = -1;
            drive_master(1'b0, 1'b1, 1'b0, 4'hF, 16'h0010, 32'd0);
            drive_master(1'b1, 1'b1, 1'b0, 4'hF, 16'h0010, 32'd0);
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (bif.m0_ack_o) a0++;
                if (bif.m1_ack_o) a1++;
                if ((bif.m0_ack_o || bif.m1_ack_o) && winner < 0) begin
                    winner = bif.m1_ack_o ? 1 : 0;
                    drive_master(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
                    drive_master(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
                end
                bif.uart_ack_i = bif.uart_cyc_o;
            end
            bif.uart_ack_i = 1'b0;
            check_value($sformatf("t2_round%0d_winner", r), winner, r % 2);
            check_value($sformatf("t2_round%0d_acks", r), a0 + a1, 1);
        end

        // 3: m1 VGA write, byte lanes 0-1
        do_txn("t3_vga_wr", 1'b1, 1'b1, 4'b0011, 16'h8010, 32'h1234_5678, 1, 1'b0, 2, 2, 3, 1'b0, 32'd0);

        // 4: unmapped region answers on cycle 1 with an error and no bus cycle
        do_txn("t4_unmapped", 1'b0, 1'b0, 4'hF, 16'hC000, 32'd0, -1, 1'b0, 3, 0, 1, 1'b1, 32'd0);

        // 5: SPI never acks, stray ACKs from other slaves must be ignored
        bif.spi_dat_i = 32'hDEAD_BEEF;
        do_txn("t5_timeout", 1'b0, 1'b0, 4'hF, 16'h4000, 32'd0, -1, 1'b1, 1, 8, 9, 1'b1, 32'd0);

        // 5b: ACK on the last allowed cycle is a success
        bif.spi_dat_i = 32'h5A5A_0002;
        do_txn("t5_ack_at_limit", 1'b1, 1'b0, 4'hF, 16'h4004, 32'd0, 7, 1'b0, 1, 8, 9, 1'b0, 32'h5A5A_0002);

        // 6: reset in the middle of a bus cycle, then m1 is served normally
        drive_master(1'b0, 1'b1, 1'b0, 4'hF, 16'h0000, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_value("t6_cyc_before_rst", {31'd0, bif.uart_cyc_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("t6_after_rst");
        rst = 1'b0;
        drive_master(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        any_ack = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bif.m0_ack_o || bif.m1_ack_o) any_ack++;
        end
        check_value("t6_no_ack", any_ack, 0);
        do_txn("t6_m1_spi", 1'b1, 1'b0, 4'hF, 16'h4008, 32'd0, 0, 1'b0, 1, 1, 2, 1'b0, 32'h5A5A_0002);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
